// File: rtl/cnt_pkg.sv
// cnt_pkg: mode encodings and all-ones helper shared by the counter files
package cnt_pkg;
  localparam logic [1:0] MODE_COUNT = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_ROR   = 2'b10;
  localparam logic [1:0] MODE_ROL   = 2'b11;
  function automatic logic [31:0] all_ones(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : (32'h1 << w) - 32'h1;
  endfunction
endpackage

// File: rtl/cnt_next_val.sv
// cnt_next_val: combinational next value and terminal event for count/load/rotate modes
module cnt_next_val
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] y_i,
  input  logic [1:0]       mode_i,
  input  logic             up_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] d_in_i,
  input  logic [WIDTH-1:0] term_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             ev_o
);
  logic inc, dec, top, bot;
  assign inc = up_i & ~down_i;
  assign dec = down_i & ~up_i;
  assign top = y_i >= term_i;
  assign bot = y_i == '0;
  // up/down are only honoured in count mode; load clamps to the terminal, rotates span full width
  always_comb begin
    nxt_o = y_i;
    ev_o  = 1'b0;
    if (mode_i == MODE_COUNT) begin
      if (inc && top) begin
        nxt_o = (SATURATE != 0) ? term_i : '0;
        ev_o  = 1'b1;
      end else if (dec && bot) begin
        nxt_o = (SATURATE != 0) ? '0 : term_i;
        ev_o  = 1'b1;
      end else if (inc) begin
        nxt_o = y_i + WIDTH'(1);
      end else if (dec) begin
        nxt_o = y_i - WIDTH'(1);
      end
    end else if (mode_i == MODE_LOAD) begin
      nxt_o = (d_in_i > term_i) ? term_i : d_in_i;
    end else if (mode_i == MODE_ROR) begin
      nxt_o = {y_i[0], y_i[WIDTH-1:1]};
    end else begin
      nxt_o = {y_i[WIDTH-2:0], y_i[WIDTH-1]};
    end
  end
endmodule

// File: rtl/cnt_nb_updown_rot.sv
// cnt_nb_updown_rot: N-bit up/down/load/rotate register with terminal pulse and limit flags; CNT_TERMINAL_EN adds a runtime terminal port
module cnt_nb_updown_rot
  import cnt_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SET_VALUE = WIDTH'(all_ones(WIDTH)),
  parameter int               SATURATE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             en,
  input  logic             up,
  input  logic             down,
  input  logic [1:0]       rlr,
  input  logic [WIDTH-1:0] d_in,
`ifdef CNT_TERMINAL_EN
  input  logic [WIDTH-1:0] term,
`endif
  output logic [WIDTH-1:0] y_out,
  output logic             term_pulse,
  output logic             at_max,
  output logic             at_min
);
  logic [WIDTH-1:0] y_q, y_d, nxt, terminal;
  logic tp_q, tp_d, ev;
`ifdef CNT_TERMINAL_EN
  assign terminal = term;
`else
  assign terminal = WIDTH'(all_ones(WIDTH));
`endif
  cnt_next_val #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_next (
    .y_i(y_q), .mode_i(rlr), .up_i(up), .down_i(down),
    .d_in_i(d_in), .term_i(terminal), .nxt_o(nxt), .ev_o(ev)
  );
  // set outranks the enabled mode operation; the event only fires on an enabled mode op
  always_comb begin
    y_d  = set ? SET_VALUE : (en ? nxt : y_q);
    tp_d = ~set & en & ev;
  end
  // register with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q  <= '0;
      tp_q <= 1'b0;
    end else begin
      y_q  <= y_d;
      tp_q <= tp_d;
    end
  end
  assign y_out      = y_q;
  assign term_pulse = tp_q;
  assign at_max     = y_q == terminal;
  assign at_min     = y_q == '0;
endmodule

// File: tb/tb_cnt_nb_updown_rot.sv
// tb_cnt_nb_updown_rot: table-driven scoreboard bench for wrap and saturate builds at WIDTH=4
module tb_cnt_nb_updown_rot;
  logic clk = 1'b0;
  logic reset = 1'b1, set = 1'b1, en = 1'b0, up = 1'b0, down = 1'b0;
  logic [1:0] rlr = 2'b00;
  logic [3:0] d_in = 4'h0;
`ifdef CNT_TERMINAL_EN
  logic [3:0] term = 4'hF;
`endif
  logic [3:0] y_w, y_s;
  logic tp_w, mx_w, mn_w, tp_s, mx_s, mn_s;
  always #5 clk = ~clk;
  cnt_nb_updown_rot #(.WIDTH(4), .SET_VALUE(4'hF), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .set(set), .en(en), .up(up), .down(down),
    .rlr(rlr), .d_in(d_in),
`ifdef CNT_TERMINAL_EN
    .term(term),
`endif
    .y_out(y_w), .term_pulse(tp_w), .at_max(mx_w), .at_min(mn_w)
  );
  cnt_nb_updown_rot #(.WIDTH(4), .SET_VALUE(4'hF), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .set(set), .en(en), .up(up), .down(down),
    .rlr(rlr), .d_in(d_in),
`ifdef CNT_TERMINAL_EN
    .term(term),
`endif
    .y_out(y_s), .term_pulse(tp_s), .at_max(mx_s), .at_min(mn_s)
  );
  typedef struct {
    logic r, s, e, u, dn;
    logic [1:0] m;
    logic [3:0] d;
    logic [3:0] y;
    logic tp;
  } vec_t;
  typedef struct {
    int dut;
    logic [3:0] y;
    logic tp;
    string nm;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  int applied = 0, miscompares = 0;
  task automatic apply(input logic r, s, e, u, dn, input logic [1:0] m, input logic [3:0] d);
    @(negedge clk);
    reset = r; set = s; en = e; up = u; down = dn; rlr = m; d_in = d;
  endtask
  task automatic expect_val(input int dut, input logic [3:0] y, input logic tp, input string nm);
    sb.push_back('{dut, y, tp, nm});
  endtask
  task automatic check;
    exp_t x;
    logic [3:0] ay;
    logic atp, amx, amn;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      ay  = x.dut != 0 ? y_s : y_w;
      atp = x.dut != 0 ? tp_s : tp_w;
      amx = x.dut != 0 ? mx_s : mx_w;
      amn = x.dut != 0 ? mn_s : mn_w;
      applied++;
      if (ay !== x.y || atp !== x.tp || amx !== (x.y == 4'hF) || amn !== (x.y == 4'h0)) begin
        miscompares++;
        $display("FAIL %s: got y=%h tp=%b max=%b min=%b, want y=%h tp=%b max=%b min=%b",
                 x.nm, ay, atp, amx, amn, x.y, x.tp, x.y == 4'hF, x.y == 4'h0);
      end
    end
  endtask
  initial begin
    tbl = '{
      '{1,1,0,0,0,2'd0,4'h0,4'h0,1'b0},
      '{1,1,1,1,0,2'd0,4'h0,4'h0,1'b0},
      '{0,1,0,0,0,2'd0,4'h0,4'hF,1'b0},
      '{0,0,1,1,0,2'd0,4'h0,4'h0,1'b1},
      '{0,0,1,0,0,2'd0,4'h0,4'h0,1'b0},
      '{0,0,1,0,1,2'd0,4'h0,4'hF,1'b1},
      '{0,0,1,1,0,2'd0,4'h0,4'h0,1'b1},
      '{0,0,1,1,0,2'd0,4'h0,4'h1,1'b0},
      '{0,0,1,1,0,2'd0,4'h0,4'h2,1'b0},
      '{0,0,1,1,1,2'd0,4'h0,4'h2,1'b0},
      '{0,0,1,0,1,2'd0,4'h0,4'h1,1'b0},
      '{0,0,1,1,0,2'd1,4'h9,4'h9,1'b0},
      '{0,0,1,0,0,2'd3,4'h0,4'h3,1'b0},
      '{0,0,1,0,0,2'd3,4'h0,4'h6,1'b0},
      '{0,0,1,0,0,2'd2,4'h0,4'h3,1'b0},
      '{0,0,1,0,0,2'd2,4'h0,4'h9,1'b0},
      '{0,0,0,1,0,2'd2,4'h0,4'h9,1'b0},
      '{0,0,0,1,0,2'd0,4'h0,4'h9,1'b0},
      '{0,0,1,0,0,2'd3,4'h0,4'h3,1'b0},
      '{1,0,1,0,0,2'd3,4'h0,4'h0,1'b0},
      '{0,0,1,0,0,2'd3,4'h0,4'h0,1'b0},
      '{0,0,1,0,0,2'd1,4'h8,4'h8,1'b0},
      '{0,0,1,0,0,2'd3,4'h0,4'h1,1'b0},
      '{0,0,1,0,0,2'd2,4'h0,4'h8,1'b0}
    };
    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].s, tbl[i].e, tbl[i].u, tbl[i].dn, tbl[i].m, tbl[i].d);
      expect_val(0, tbl[i].y, tbl[i].tp, $sformatf("vec%0d", i));
      check();
    end
    apply(0,0,1,0,0,2'd1,4'hE);
    expect_val(0, 4'hE, 1'b0, "ldE_w"); expect_val(1, 4'hE, 1'b0, "ldE_s"); check();
    apply(0,0,1,1,0,2'd0,4'h0);
    expect_val(0, 4'hF, 1'b0, "up1_w"); expect_val(1, 4'hF, 1'b0, "up1_s"); check();
    apply(0,0,1,1,0,2'd0,4'h0);
    expect_val(0, 4'h0, 1'b1, "up2_w"); expect_val(1, 4'hF, 1'b1, "up2_s"); check();
    apply(0,0,1,1,0,2'd0,4'h0);
    expect_val(0, 4'h1, 1'b0, "up3_w"); expect_val(1, 4'hF, 1'b1, "up3_s"); check();
    apply(0,0,1,0,0,2'd1,4'h0);
    expect_val(0, 4'h0, 1'b0, "ld0_w"); expect_val(1, 4'h0, 1'b0, "ld0_s"); check();
    apply(0,0,1,0,1,2'd0,4'h0);
    expect_val(0, 4'hF, 1'b1, "dn0_w"); expect_val(1, 4'h0, 1'b1, "dn0_s"); check();
    apply(0,0,0,0,1,2'd0,4'h0);
    expect_val(0, 4'hF, 1'b0, "enlo_w"); expect_val(1, 4'h0, 1'b0, "enlo_s"); check();
    apply(0,1,1,0,1,2'd0,4'h0);
    expect_val(0, 4'hF, 1'b0, "set_w"); expect_val(1, 4'hF, 1'b0, "set_s"); check();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
